// File: rtl/tx_axis_frame_arbiter.sv
// tx_axis_frame_arbiter
// Frame-level round-robin arbiter that feeds the single AXI-Stream input of
// tx_mac from NUM_PORTS frame sources. One source owns the output for a whole
// frame. The output is registered through a two-entry skid buffer, so every
// ready path is cut by a register.
module tx_axis_frame_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_PORTS  = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic [NUM_PORTS-1:0]            i_port_en,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_trdy,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_trdy,
    output logic [NUM_PORTS-1:0]            o_grant,
    output logic                            o_frame_done
);

    localparam int          IDXW = $clog2(NUM_PORTS);
    localparam int unsigned NP   = NUM_PORTS;

    localparam logic [0:0] ST_ARB = 1'b0;
    localparam logic [0:0] ST_FWD = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [NUM_PORTS-1:0]  grant_q, grant_d;
    logic [NUM_PORTS-1:0]  trdy_q, trdy_d;
    logic [IDXW-1:0]       gidx_q, gidx_d;
    logic [IDXW-1:0]       last_q, last_d;
    logic                  done_q, done_d;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
    logic                  out_last_q, out_last_d;

    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [KEEP_WIDTH-1:0] skid_keep_q, skid_keep_d;
    logic                  skid_last_q, skid_last_d;

    logic [NUM_PORTS-1:0]  req;
    logic                  acc;
    logic                  pick_found;
    logic [IDXW-1:0]       pick_idx;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [KEEP_WIDTH-1:0] beat_keep;
    logic                  beat_last;

    assign req = s_axis_tvalid & i_port_en;
    // trdy_q is only ever non-zero on the granted port, so this is the handshake.
    assign acc = |(s_axis_tvalid & trdy_q);

    // Select the beat presented by the granted port.
    always_comb begin
        beat_data = '0;
        beat_keep = '0;
        beat_last = 1'b0;
        for (int unsigned p = 0; p < NP; p++) begin
            if (grant_q[p]) begin
                beat_data = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
                beat_keep = s_axis_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
                beat_last = s_axis_tlast[p];
            end
        end
    end

    // Round-robin pick: first requester after the last granted port, with wrap.
    always_comb begin
        int unsigned     cand;
        logic [IDXW-1:0] cidx;
        cand       = 0;
        cidx       = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            cand = (32'(last_q) + 32'd1 + i) % NP;
            cidx = cand[IDXW-1:0];
            if (!pick_found && req[cidx]) begin
                pick_found = 1'b1;
                pick_idx   = cidx;
            end
        end
    end

    // Frame ownership: grant on a pick, release once the tlast beat is taken.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (pick_found) begin
                    state_d           = ST_FWD;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    gidx_d            = pick_idx;
                end
            end
            default: begin
                if (acc && beat_last) begin
                    state_d = ST_ARB;
                    grant_d = '0;
                    last_d  = gidx_q;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    // Skid buffer: the output register refills from skid first, then from the
    // input. trdy is registered from the next skid state, so a beat can only
    // arrive while skid is empty and at most two beats are ever held.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_keep_d  = skid_keep_q;
        skid_last_d  = skid_last_q;
        if (!out_valid_q || m_axis_trdy) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_keep_d   = skid_keep_q;
                out_last_d   = skid_last_q;
                skid_valid_d = 1'b0;
            end else if (acc) begin
                out_valid_d = 1'b1;
                out_data_d  = beat_data;
                out_keep_d  = beat_keep;
                out_last_d  = beat_last;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = beat_data;
            skid_keep_d  = beat_keep;
            skid_last_d  = beat_last;
        end
        trdy_d = (state_d == ST_FWD && !skid_valid_d) ? grant_d : '0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_ARB;
            grant_q      <= '0;
            trdy_q       <= '0;
            gidx_q       <= '0;
            last_q       <= IDXW'(NUM_PORTS - 1);
            done_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_keep_q  <= '0;
            skid_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            trdy_q       <= trdy_d;
            gidx_q       <= gidx_d;
            last_q       <= last_d;
            done_q       <= done_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_keep_q  <= skid_keep_d;
            skid_last_q  <= skid_last_d;
        end
    end

    assign s_axis_trdy   = trdy_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign o_grant       = grant_q;
    assign o_frame_done  = done_q;

endmodule

// File: doc/tx_axis_frame_arbiter.md
# tx_axis_frame_arbiter

Frame-level round-robin arbiter that shares the single AXI-Stream input of `tx_mac` between `NUM_PORTS` independent AXI-Stream frame sources. Sits directly upstream of `tx_mac`; its `m_axis_*` port connects one-to-one to the `tx_mac` `s_axis_*` port. Grants one source for a whole frame, never interleaves beats of different frames, and registers the output through a 2-entry skid buffer so no ready path is combinational across the block.

## Interface
- `DATA_WIDTH`, 32, beat width in bits; multiple of 8.
- `KEEP_WIDTH`, `DATA_WIDTH/8`, tkeep width.
- `NUM_PORTS`, 4, number of requesters; legal range 2..8.
- `i_clk`  in  1  sole clock; all logic on rising edge.
- `i_reset`  in  1  reset; synchronous and active-high.
- `i_port_en`  in  NUM_PORTS  per-port enable mask; sampled only in ARB.
- `s_axis_tdata`  in  NUM_PORTS*DATA_WIDTH  flattened; port p at [p*DATA_WIDTH +: DATA_WIDTH].
- `s_axis_tkeep`  in  NUM_PORTS*KEEP_WIDTH  flattened likewise.
- `s_axis_tvalid`  in  NUM_PORTS  per-port valid.
- `s_axis_tlast`  in  NUM_PORTS  per-port end of frame.
- `s_axis_trdy`  out  NUM_PORTS  per-port ready; registered.
- `m_axis_tdata`  out  DATA_WIDTH  to tx_mac.
- `m_axis_tkeep`  out  KEEP_WIDTH  to tx_mac.
- `m_axis_tvalid`  out  1  registered.
- `m_axis_tlast`  out  1  registered.
- `m_axis_trdy`  in  1  from tx_mac.
- `o_grant`  out  NUM_PORTS  one-hot owner of current frame; 0 when none.
- `o_frame_done`  out  1  one-cycle pulse when the tlast beat is accepted from the granted port.

## Operation
- States: ARB, FWD.
- ARB: requester set = `s_axis_tvalid & i_port_en`. If non-empty, pick first set bit scanning from `(last_grant+1) mod NUM_PORTS` upward with wrap; register `o_grant`, go FWD. If empty, stay ARB, `o_grant`=0.
- FWD: `s_axis_trdy[g]` = ~skid_valid; all other trdy bits 0. Beat accepted when `s_axis_tvalid[g] & s_axis_trdy[g]`. Accepted beat with tlast: pulse `o_frame_done`, `last_grant`<=g, clear `o_grant`, go ARB.
- `i_port_en` changes during FWD do not truncate the current frame; take effect at next ARB.
- Skid buffer: output register (out_valid/data) plus one skid entry. Accepted beat goes to output register if it is empty or being drained by `m_axis_trdy` this cycle; otherwise to skid. When output drains and skid valid, skid moves to output. Beat order strictly preserved; no beat lost or duplicated.
- Idle source mid-frame (tvalid low in FWD): hold grant, forward nothing, wait indefinitely.
- tkeep passed through unmodified; no checks on tkeep legality.

## Timing
- Reset (i_reset high at a rising edge): state ARB, `o_grant`=0, `last_grant`=NUM_PORTS-1 (so port 0 wins first), `s_axis_trdy`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`/`tkeep`=0, `o_frame_done`=0, skid empty. Reset mid-frame discards both buffered beats; no tlast emitted.
- Arbitration: requester visible in cycle N -> `o_grant` and FWD in N+1; `s_axis_trdy[g]` high in N+1 (skid empty).
- Latency: beat accepted in cycle N -> `m_axis_tvalid` high in N+1 when output register free.
- Throughput: 1 beat/cycle during FWD with `m_axis_trdy` held high.
- Frame gap: tlast accepted in N -> ARB in N+1 -> next grant in N+2; at least one idle input cycle between frames.
- Backpressure: `m_axis_trdy` low -> at most one further beat accepted (into skid), then trdy drops next cycle. m_axis_tdata/tkeep/tlast stable while tvalid high and trdy low.

## Test plan
- Single port 0, 4-beat frame 0x11111111..0x44444444, tkeep=0xF, last beat tkeep=0x3, m_axis_trdy=1 -> identical 4 beats on m_axis, first at grant+1, tlast on beat 4, one `o_frame_done` pulse, `o_grant`=0001 throughout.
- All 4 ports continuously valid, 2-beat frames -> grant order 0,1,2,3,0; each frame contiguous; exactly one idle ARB cycle between frames.
- Port 2 valid, `i_port_en`=1011 -> port 2 never granted; set bit 2 mid-frame of port 0 -> port 2 granted in the next ARB after port 1 (if requesting).
- 8-beat frame with `m_axis_trdy` toggling 1,0,0,1 pattern -> output beats equal input order, no drop/duplicate, data stable while stalled, at most 2 beats buffered.
- Reset asserted on beat 3 of a 6-beat frame -> all outputs at reset values next cycle; after release, next frame starts at port 0 with fresh data only.
